scsi_initiator: RTL and testbench
=================================

# scsi_initiator

Initiator-side SCSI bus engine for the Mac Plus core. It selects one target on the parallel bus, sends a 6- or 10-byte CDB, moves data through a 1 KiB host byte buffer, and collects the status and message bytes. It sits between the host command logic and the target devices on the shared bus. It follows the REQ/ACK handshake the targets expect, including their registered ACK edge detection.

## Interface
Parameters:
- HOST_ID, 7, initiator bit driven on the data bus during selection
- SEL_TIMEOUT, 50000, cycles to wait for bsy after sel is asserted
- SETTLE, 4, cycles after ack falls before req/phase are sampled again (minimum 3)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sel  out  1  selection
- atn  out  1  attention, tied 0
- bsy  in  1  target holds bus
- msg, cd, io  in  1 each  phase lines from the target
- req  in  1  target request
- ack  out  1  initiator acknowledge
- dout  out  8  data to target
- din  in  8  data from target
- start  in  1  one-cycle pulse, accepted only in IDLE
- target_id  in  3  target to select, latched on start
- cdb_wr  in  1  CDB byte write, ignored unless IDLE
- cdb_addr  in  4  CDB byte index
- cdb_data  in  8  CDB byte
- buf_addr  out  10  data_cnt[9:0]
- buf_wr  out  1  one-cycle write of buf_wdata
- buf_wdata  out  8  byte received from target
- buf_rdata  in  8  byte to send; 1-cycle read latency from buf_addr
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at end of transaction
- result  out  2  0 ok, 1 selection timeout, 2 unexpected bus free, 3 reserved phase seen
- status  out  8  last status byte
- msg_byte  out  8  last message byte
- data_cnt  out  32  data bytes transferred

## Operation
- CDB length is decoded from the group bits cdb[0][7:5]: groups 001 and 010 use 10 bytes; all other groups use 6 bytes.
- States:
  - IDLE: on start, clear data_cnt, cmd_cnt, result, and the message-seen flag. Go to SELECT.
  - SELECT: sel=1. dout = (1<<HOST_ID) | (1<<target_id). A timeout counter counts up.
    - If bsy: sel=0 on the next cycle, go to SETTLE.
    - If the counter reaches SEL_TIMEOUT with bsy still low: result=1, go to DONE.
  - WAIT_REQ: if bsy is low, go to DONE. result=2 unless a message byte has been received. Otherwise, on req, decode {msg,cd,io}, drive or capture the byte, and go to ACK.
    - 010 (command): dout = cdb[cmd_cnt].
    - 000 (data to target): dout = buf_rdata.
    - 001 (data from target): buf_wdata = din, buf_wr pulse.
    - 011 (status): status = din.
    - 111 (message in): msg_byte = din, set the message-seen flag.
    - 100, 101, 110: dout = 0, result=3. The transaction continues.
  - ACK: ack=1. dout is held. When req is sampled low, set ack=0. Increment cmd_cnt (command phase) or data_cnt (data phases). Go to SETTLE.
  - SETTLE: wait SETTLE cycles, then go to WAIT_REQ.
  - DONE: done=1 for one cycle, then go to IDLE.
- dout holds its value from the WAIT_REQ decode until ack falls. It is 0 in IDLE.
- cmd_cnt saturates at 9. A command phase with cmd_cnt at the CDB length sends 0x00.
- data_cnt wraps modulo 2^32. buf_addr wraps every 1024 bytes; the host refills or drains the buffer.
- The block has no request watchdog: WAIT_REQ waits indefinitely while bsy is high.

## Timing
- Reset values: sel, atn, ack, buf_wr, busy, done = 0; dout, result, status, msg_byte, data_cnt, buf_addr, buf_wdata = 0; state IDLE.
- rst mid-transaction drops sel and ack on the next edge. Counters clear. No done pulse is issued.
- A start pulse outside IDLE is ignored.
- cdb_wr and start in the same cycle: the CDB byte is written before being latched.
- Selection: sel rises 1 cycle after start. sel falls 1 cycle after bsy is sampled high.
- ack rises 1 cycle after req is sampled in WAIT_REQ. ack is held at least until req is sampled low.
- The next req is not sampled before SETTLE cycles after ack falls. This covers the target's 2-cycle registered ack edge and its counter update.
- buf_addr is stable for at least SETTLE cycles before buf_rdata is used.
- Bus free after the message byte gives done 1 cycle after bsy is sampled low.

## Test plan
Each scenario pairs the block with the scsi target model, ID 0, mounted 64 blocks.
- TEST UNIT READY (CDB 00 00 00 00 00 00) -> no data phase, status=0x00, msg_byte=0x00, result=0, data_cnt=0, single done pulse.
- READ(6) (CDB 08 00 00 05 01 00) -> 512 buf_wr pulses with buf_addr 0..511, data equal to image block 5, status 0x00, result 0.
- INQUIRY allocation 36 (CDB 12 00 00 00 24 00) -> 36 bytes: byte 4 = 32, bytes 9..15 = "SEAGATE", bytes 26..31 = "ST225N".
- WRITE(6) of block 2 with buf_rdata = addr[7:0] -> target sector buffer holds 00..FF twice, image write of LBA 2 requested, status 0x00.
- start with target_id=3 and no device -> sel held for exactly SEL_TIMEOUT cycles, result=1, done pulse, sel=0 afterwards.
- Opcode 0xFF (6-byte CDB) -> status 0x02, msg_byte 0x00, result 0. Separately, rst asserted mid-READ -> ack=0 and sel=0 one cycle later, busy=0, no done pulse.

Source files
------------

// File: rtl/scsi_initiator_if.sv
// Parallel SCSI bus signals between the initiator engine and the targets.
interface scsi_initiator_if;
  logic       sel;
  logic       atn;
  logic       bsy;
  logic       msg;
  logic       cd;
  logic       io;
  logic       req;
  logic       ack;
  logic [7:0] dout;
  logic [7:0] din;

  modport master (
    output sel, atn, ack, dout,
    input  bsy, msg, cd, io, req, din
  );

  modport slave (
    input  sel, atn, ack, dout,
    output bsy, msg, cd, io, req, din
  );
endinterface

// File: rtl/scsi_initiator.sv
// Initiator-side SCSI engine: selects a target, sends the CDB, moves data
// through the host byte buffer and collects status and message bytes.
module scsi_initiator #(
  parameter int unsigned HOST_ID     = 7,
  parameter int unsigned SEL_TIMEOUT = 50000,
  parameter int unsigned SETTLE      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  scsi_initiator_if.master     bus,
  input  logic                 start,
  input  logic [2:0]           target_id,
  input  logic                 cdb_wr,
  input  logic [3:0]           cdb_addr,
  input  logic [7:0]           cdb_data,
  output logic [9:0]           buf_addr,
  output logic                 buf_wr,
  output logic [7:0]           buf_wdata,
  input  logic [7:0]           buf_rdata,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           result,
  output logic [7:0]           status,
  output logic [7:0]           msg_byte,
  output logic [31:0]          data_cnt
);

  localparam int unsigned TMO_W   = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
  localparam int unsigned SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CDB_MAX = 10;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEL_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [7:0]       HOST_BIT = 8'(1 << HOST_ID);
  localparam logic [3:0]       CMD_SAT  = 4'd9;

  localparam logic [2:0] PH_DOUT = 3'b000;
  localparam logic [2:0] PH_DIN  = 3'b001;
  localparam logic [2:0] PH_CMD  = 3'b010;
  localparam logic [2:0] PH_STAT = 3'b011;
  localparam logic [2:0] PH_MSGI = 3'b111;

  localparam logic [1:0] RES_OK       = 2'd0;
  localparam logic [1:0] RES_SEL_TMO  = 2'd1;
  localparam logic [1:0] RES_BUS_FREE = 2'd2;
  localparam logic [1:0] RES_RSV_PH   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_REQ,
    S_ACK,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t state_q, state_n;

  logic             sel_q, sel_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             buf_wr_q, buf_wr_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       buf_wdata_q, buf_wdata_d;
  logic [1:0]       result_q, result_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       msg_byte_q, msg_byte_d;
  logic [31:0]      data_cnt_q, data_cnt_d;
  logic [3:0]       cmd_cnt_q, cmd_cnt_d;
  logic             msg_seen_q, msg_seen_d;
  logic [2:0]       phase_q, phase_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [SET_W-1:0] settle_q, settle_d;

  logic [7:0]       cdb_q [CDB_MAX];
  logic [3:0]       cdb_len;
  logic [7:0]       cmd_byte;
  logic [2:0]       bus_phase;

  assign bus_phase = {bus.msg, bus.cd, bus.io};

  // Groups 1 and 2 carry 10-byte CDBs; past the CDB end the target gets zeros.
  assign cdb_len  = (cdb_q[0][7:5] == 3'b001 || cdb_q[0][7:5] == 3'b010) ? 4'd10 : 4'd6;
  assign cmd_byte = (cmd_cnt_q < cdb_len) ? cdb_q[cmd_cnt_q] : 8'h00;

  // CDB storage is host-writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CDB_MAX); i++) cdb_q[i] <= '0;
    end else if (cdb_wr && state_q == S_IDLE && cdb_addr < 4'(CDB_MAX)) begin
      cdb_q[cdb_addr] <= cdb_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:     if (start) state_n = S_SELECT;
      S_SELECT: begin
        if (bus.bsy)                state_n = S_SETTLE;
        else if (tmo_q == TMO_LAST) state_n = S_DONE;
      end
      S_WAIT_REQ: begin
        if (!bus.bsy)    state_n = S_DONE;
        else if (bus.req) state_n = S_ACK;
      end
      S_ACK:      if (!bus.req) state_n = S_SETTLE;
      S_SETTLE:   if (settle_q == SET_LAST) state_n = S_WAIT_REQ;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Output and datapath next values; bus strobes follow the next state so they are registered.
  always_comb begin
    sel_d       = (state_n == S_SELECT);
    ack_d       = (state_n == S_ACK);
    busy_d      = (state_n != S_IDLE);
    done_d      = (state_n == S_DONE);
    buf_wr_d    = 1'b0;
    dout_d      = dout_q;
    buf_wdata_d = buf_wdata_q;
    result_d    = result_q;
    status_d    = status_q;
    msg_byte_d  = msg_byte_q;
    data_cnt_d  = data_cnt_q;
    cmd_cnt_d   = cmd_cnt_q;
    msg_seen_d  = msg_seen_q;
    phase_d     = phase_q;
    tmo_d       = '0;
    settle_d    = '0;

    case (state_q)
      S_IDLE: begin
        dout_d = 8'h00;
        if (start) begin
          data_cnt_d = '0;
          cmd_cnt_d  = '0;
          result_d   = RES_OK;
          msg_seen_d = 1'b0;
          dout_d     = HOST_BIT | (8'd1 << target_id);
        end
      end
      S_SELECT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.bsy)                dout_d   = 8'h00;
        else if (tmo_q == TMO_LAST) result_d = RES_SEL_TMO;
      end
      S_WAIT_REQ: begin
        if (!bus.bsy) begin
          if (!msg_seen_q) result_d = RES_BUS_FREE;
        end else if (bus.req) begin
          phase_d = bus_phase;
          case (bus_phase)
            PH_CMD:  dout_d = cmd_byte;
            PH_DOUT: dout_d = buf_rdata;
            PH_DIN: begin
              dout_d      = 8'h00;
              buf_wdata_d = bus.din;
              buf_wr_d    = 1'b1;
            end
            PH_STAT: begin
              dout_d   = 8'h00;
              status_d = bus.din;
            end
            PH_MSGI: begin
              dout_d     = 8'h00;
              msg_byte_d = bus.din;
              msg_seen_d = 1'b1;
            end
            default: begin
              dout_d   = 8'h00;
              result_d = RES_RSV_PH;
            end
          endcase
        end
      end
      S_ACK: begin
        if (!bus.req) begin
          if (phase_q == PH_CMD && cmd_cnt_q != CMD_SAT) cmd_cnt_d = cmd_cnt_q + 4'd1;
          if (phase_q == PH_DOUT || phase_q == PH_DIN)  data_cnt_d = data_cnt_q + 32'd1;
        end
      end
      S_SETTLE: settle_d = settle_q + SET_W'(1);
      S_DONE:   dout_d = 8'h00;
      default: ;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      buf_wr_q    <= 1'b0;
      dout_q      <= '0;
      buf_wdata_q <= '0;
      result_q    <= RES_OK;
      status_q    <= '0;
      msg_byte_q  <= '0;
      data_cnt_q  <= '0;
      cmd_cnt_q   <= '0;
      msg_seen_q  <= 1'b0;
      phase_q     <= '0;
      tmo_q       <= '0;
      settle_q    <= '0;
    end else begin
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      buf_wr_q    <= buf_wr_d;
      dout_q      <= dout_d;
      buf_wdata_q <= buf_wdata_d;
      result_q    <= result_d;
      status_q    <= status_d;
      msg_byte_q  <= msg_byte_d;
      data_cnt_q  <= data_cnt_d;
      cmd_cnt_q   <= cmd_cnt_d;
      msg_seen_q  <= msg_seen_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.atn   = 1'b0;
  assign bus.ack   = ack_q;
  assign bus.dout  = dout_q;
  assign buf_addr  = data_cnt_q[9:0];
  assign buf_wr    = buf_wr_q;
  assign buf_wdata = buf_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign status    = status_q;
  assign msg_byte  = msg_byte_q;
  assign data_cnt  = data_cnt_q;

endmodule

// File: tb/tb_scsi_initiator.sv
// Bench for scsi_initiator: a behavioural target on the bus plus a scoreboard of buffer writes.
module tb_scsi_initiator;
  localparam int unsigned SEL_TO   = 40;
  localparam int unsigned SETTLE_C = 4;

  localparam logic [2:0] PH_DOUT = 3'b000;
  localparam logic [2:0] PH_DIN  = 3'b001;
  localparam logic [2:0] PH_CMD  = 3'b010;
  localparam logic [2:0] PH_STAT = 3'b011;
  localparam logic [2:0] PH_MSGI = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  target_id;
  logic        cdb_wr;
  logic [3:0]  cdb_addr;
  logic [7:0]  cdb_data;
  logic [9:0]  buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_rdata;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [7:0]  status;
  logic [7:0]  msg_byte;
  logic [31:0] data_cnt;

  scsi_initiator_if bus ();

  scsi_initiator #(.HOST_ID(7), .SEL_TIMEOUT(SEL_TO), .SETTLE(SETTLE_C)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .start(start), .target_id(target_id),
    .cdb_wr(cdb_wr), .cdb_addr(cdb_addr), .cdb_data(cdb_data),
    .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .busy(busy), .done(done), .result(result), .status(status),
    .msg_byte(msg_byte), .data_cnt(data_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  bit          sess_ok;
  logic [17:0] exp_q [$];
  logic [17:0] mon_exp;
  logic [7:0]  h_cdb [10];
  int          h_len;
  logic [7:0]  inq [36];
  logic [7:0]  sector [512];

  // Host buffer read port: one-cycle latency, contents equal to the low address byte.
  always @(posedge clk) buf_rdata <= buf_addr[7:0];

  // Scoreboard on the buffer write port and done-pulse counter.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (buf_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL buf_wr_unexpected got addr=%0d data=%02h want no write", buf_addr, buf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({buf_addr, buf_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL buf_wr got addr=%0d data=%02h want addr=%0d data=%02h",
                   buf_addr, buf_wdata, mon_exp[17:8], mon_exp[7:0]);
        end
      end
    end
  end

  function automatic logic [7:0] img(input int lba, input int i);
    return 8'((lba * 131 + i * 7 + (i >> 8)) & 255);
  endfunction

  task automatic set_cdb6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    h_cdb[0] = b0; h_cdb[1] = b1; h_cdb[2] = b2;
    h_cdb[3] = b3; h_cdb[4] = b4; h_cdb[5] = b5;
    h_len = 6;
  endtask

  // Writes CDB bytes high to low; byte 0 goes in the same cycle as start.
  task automatic host_issue(input logic [2:0] tid);
    for (int i = h_len - 1; i >= 1; i--) begin
      cdb_wr = 1'b1; cdb_addr = 4'(i); cdb_data = h_cdb[i];
      @(negedge clk);
    end
    cdb_wr = 1'b1; cdb_addr = 4'd0; cdb_data = h_cdb[0];
    start = 1'b1; target_id = tid;
    @(negedge clk);
    cdb_wr = 1'b0; start = 1'b0;
  endtask

  task automatic bus_release();
    bus.bsy = 1'b0; bus.req = 1'b0;
    {bus.msg, bus.cd, bus.io} = 3'b000;
    bus.din = 8'h00;
  endtask

  task automatic tgt_select(input logic [7:0] exp_dout);
    int n = 0;
    while (!bus.sel && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (bus.sel !== 1'b1 || n != 0) begin
      errors++; sess_ok = 1'b0;
      $display("FAIL sel_rise got sel=%b after %0d cycles want 1 after 0", bus.sel, n);
      return;
    end
    checks++;
    if (bus.dout !== exp_dout) begin
      errors++;
      $display("FAIL sel_dout got %02h want %02h", bus.dout, exp_dout);
    end
    bus.bsy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sel !== 1'b0) begin
      errors++;
      $display("FAIL sel_fall got sel=%b want 0", bus.sel);
    end
  endtask

  // One REQ/ACK byte; entered and left on a falling clock edge.
  task automatic tgt_xfer(input logic [2:0] ph, input logic [7:0] tx, output logic [7:0] rx);
    int n;
    rx = 8'h00;
    if (!sess_ok) return;
    {bus.msg, bus.cd, bus.io} = ph;
    bus.din = tx;
    bus.req = 1'b1;
    n = 0;
    while (!bus.ack && n < 64) begin @(negedge clk); n++; end
    if (!bus.ack) begin
      checks++; errors++; sess_ok = 1'b0; bus.req = 1'b0;
      $display("FAIL ack_rise phase=%b got ack=0 want 1", ph);
      return;
    end
    rx = bus.dout;
    bus.req = 1'b0;
    n = 0;
    while (bus.ack && n < 16) begin @(negedge clk); n++; end
    if (bus.ack) begin
      checks++; errors++; sess_ok = 1'b0;
      $display("FAIL ack_fall phase=%b got ack=1 want 0", ph);
      return;
    end
    @(negedge clk);
  endtask

  // Behavioural target ID 0: command, optional data, status 0/02, message 00, bus free.
  task automatic tgt_session(input int extra_cmd, input bit rsv, input bit abort);
    logic [7:0] rx;
    logic [7:0] cmd [10];
    logic [7:0] st;
    int len, n;
    sess_ok = 1'b1;
    tgt_select(8'h81);
    if (!sess_ok) begin bus_release(); return; end
    tgt_xfer(PH_CMD, 8'h00, rx);
    cmd[0] = rx;
    len = (rx[7:5] == 3'b001 || rx[7:5] == 3'b010) ? 10 : 6;
    for (int i = 1; i < len; i++) begin
      tgt_xfer(PH_CMD, 8'h00, rx);
      cmd[i] = rx;
    end
    for (int i = 0; i < len; i++) begin
      checks++;
      if (cmd[i] !== h_cdb[i]) begin
        errors++;
        $display("FAIL cdb_byte%0d got %02h want %02h", i, cmd[i], h_cdb[i]);
      end
    end
    for (int e = 0; e < extra_cmd; e++) begin
      tgt_xfer(PH_CMD, 8'h00, rx);
      checks++;
      if (rx !== 8'h00) begin
        errors++;
        $display("FAIL cdb_pad got %02h want 00", rx);
      end
    end
    if (abort) begin bus_release(); return; end
    if (rsv) begin
      tgt_xfer(3'b100, 8'h5A, rx);
      checks++;
      if (rx !== 8'h00) begin
        errors++;
        $display("FAIL rsv_dout got %02h want 00", rx);
      end
    end
    st = 8'h00;
    case (cmd[0])
      8'h00: ;
      8'h08: begin
        for (int i = 0; i < 512 * int'(cmd[4]); i++) begin
          exp_q.push_back({10'(i), img(int'(cmd[3]), i)});
          tgt_xfer(PH_DIN, img(int'(cmd[3]), i), rx);
        end
      end
      8'h0A: begin
        for (int i = 0; i < 512; i++) begin
          tgt_xfer(PH_DOUT, 8'h00, rx);
          sector[i] = rx;
        end
      end
      8'h12: begin
        n = (int'(cmd[4]) < 36) ? int'(cmd[4]) : 36;
        for (int i = 0; i < n; i++) begin
          exp_q.push_back({10'(i), inq[i]});
          tgt_xfer(PH_DIN, inq[i], rx);
        end
      end
      default: st = 8'h02;
    endcase
    tgt_xfer(PH_STAT, st, rx);
    tgt_xfer(PH_MSGI, 8'h00, rx);
    bus_release();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done got no done pulse want one", name);
      bus_release();
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  task automatic check_end(input string name, input logic [1:0] exp_res,
                           input logic [7:0] exp_st, input logic [31:0] exp_cnt, input int d0);
    repeat (3) @(negedge clk);
    checks++;
    if (result !== exp_res) begin errors++; $display("FAIL %s_result got %0d want %0d", name, result, exp_res); end
    checks++;
    if (status !== exp_st) begin errors++; $display("FAIL %s_status got %02h want %02h", name, status, exp_st); end
    checks++;
    if (msg_byte !== 8'h00) begin errors++; $display("FAIL %s_msg got %02h want 00", name, msg_byte); end
    checks++;
    if (data_cnt !== exp_cnt) begin errors++; $display("FAIL %s_count got %0d want %0d", name, data_cnt, exp_cnt); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", name, done_cnt - d0); end
    checks++;
    if (busy !== 1'b0 || bus.sel !== 1'b0) begin
      errors++; $display("FAIL %s_idle got busy=%b sel=%b want 0 0", name, busy, bus.sel);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_pending got %0d writes outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sel, bus.atn, bus.ack, buf_wr, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {bus.sel, bus.atn, bus.ack, buf_wr, busy, done});
    end
    checks++;
    if ({bus.dout, result, status, msg_byte, data_cnt, buf_addr, buf_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got dout=%02h res=%0d st=%02h msg=%02h cnt=%0d addr=%0d wd=%02h want all 0",
                         bus.dout, result, status, msg_byte, data_cnt, buf_addr, buf_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tur();
    int d0 = done_cnt;
    set_cdb6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b0);
    wait_done("tur");
    check_end("tur", 2'd0, 8'h00, 32'd0, d0);
  endtask

  task automatic test_read6();
    int d0 = done_cnt;
    set_cdb6(8'h08, 8'h00, 8'h00, 8'h05, 8'h01, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b0);
    wait_done("read6");
    check_end("read6", 2'd0, 8'h00, 32'd512, d0);
  endtask

  task automatic test_inquiry();
    int d0 = done_cnt;
    logic [55:0] vend;
    logic [47:0] prod;
    vend = "SEAGATE";
    prod = "ST225N";
    for (int i = 0; i < 36; i++) inq[i] = 8'h20;
    inq[0] = 8'h00; inq[1] = 8'h00; inq[2] = 8'h01; inq[3] = 8'h01; inq[4] = 8'd32;
    for (int k = 0; k < 7; k++) inq[9 + k]  = vend[8 * (6 - k) +: 8];
    for (int k = 0; k < 6; k++) inq[26 + k] = prod[8 * (5 - k) +: 8];
    set_cdb6(8'h12, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b0);
    wait_done("inquiry");
    check_end("inquiry", 2'd0, 8'h00, 32'd36, d0);
  endtask

  task automatic test_write6();
    int d0 = done_cnt;
    int bad = 0;
    set_cdb6(8'h0A, 8'h00, 8'h00, 8'h02, 8'h01, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b0);
    wait_done("write6");
    for (int i = 0; i < 512; i++) begin
      checks++;
      if (sector[i] !== 8'(i) && bad < 4) begin
        errors++; bad++;
        $display("FAIL write6_byte%0d got %02h want %02h", i, sector[i], 8'(i));
      end else if (sector[i] !== 8'(i)) begin
        errors++;
      end
    end
    check_end("write6", 2'd0, 8'h00, 32'd512, d0);
  endtask

  task automatic test_sel_timeout();
    int d0 = done_cnt;
    int n = 0;
    set_cdb6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    host_issue(3'd3);
    checks++;
    if (bus.dout !== 8'h88) begin errors++; $display("FAIL seltmo_dout got %02h want 88", bus.dout); end
    while (bus.sel && n < int'(SEL_TO) + 10) begin @(negedge clk); n++; end
    checks++;
    if (n != int'(SEL_TO)) begin errors++; $display("FAIL seltmo_len got %0d cycles want %0d", n, SEL_TO); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL seltmo_done got %b want 1", done); end
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 2'd1) begin errors++; $display("FAIL seltmo_result got %0d want 1", result); end
    checks++;
    if (bus.sel !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL seltmo_after got sel=%b pulses=%0d want 0 1", bus.sel, done_cnt - d0);
    end
  endtask

  task automatic test_bad_opcode();
    int d0 = done_cnt;
    set_cdb6(8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    host_issue(3'd0);
    tgt_session(1, 1'b0, 1'b0);
    wait_done("badop");
    check_end("badop", 2'd0, 8'h02, 32'd0, d0);
  endtask

  task automatic test_cdb10();
    int d0 = done_cnt;
    h_cdb[0] = 8'h25;
    for (int i = 1; i < 10; i++) h_cdb[i] = 8'(8'h30 + i);
    h_len = 10;
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b0);
    wait_done("cdb10");
    check_end("cdb10", 2'd0, 8'h02, 32'd0, d0);
  endtask

  task automatic test_reserved_phase();
    int d0 = done_cnt;
    set_cdb6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b1, 1'b0);
    wait_done("rsv");
    check_end("rsv", 2'd3, 8'h00, 32'd0, d0);
  endtask

  task automatic test_bus_free();
    int d0 = done_cnt;
    set_cdb6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    host_issue(3'd0);
    tgt_session(0, 1'b0, 1'b1);
    wait_done("busfree");
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 2'd2) begin errors++; $display("FAIL busfree_result got %0d want 2", result); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL busfree_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_read();
    int d0 = done_cnt;
    int n = 0;
    logic [7:0] rx;
    set_cdb6(8'h08, 8'h00, 8'h00, 8'h05, 8'h01, 8'h00);
    host_issue(3'd0);
    sess_ok = 1'b1;
    tgt_select(8'h81);
    for (int i = 0; i < 6; i++) tgt_xfer(PH_CMD, 8'h00, rx);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({10'(i), img(5, i)});
      tgt_xfer(PH_DIN, img(5, i), rx);
    end
    exp_q.push_back({10'(3), img(5, 3)});
    {bus.msg, bus.cd, bus.io} = PH_DIN;
    bus.din = img(5, 3);
    bus.req = 1'b1;
    while (!bus.ack && n < 64) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0 || bus.sel !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_bus got ack=%b sel=%b busy=%b want 0 0 0", bus.ack, bus.sel, busy);
    end
    checks++;
    if (data_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", data_cnt); end
    bus_release();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rstmid_pending got %0d writes outstanding want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    start = 1'b0; target_id = 3'd0;
    cdb_wr = 1'b0; cdb_addr = 4'd0; cdb_data = 8'h00;
    bus_release();
    @(negedge clk);
    test_reset();
    test_tur();
    test_read6();
    test_inquiry();
    test_write6();
    test_sel_timeout();
    test_bad_opcode();
    test_cdb10();
    test_reserved_phase();
    test_bus_free();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got no finish want finish before 5ms");
    $fatal(1);
  end

endmodule
